// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: signal bundle between the M-stage pipeline (master) and the CP0 controller (slave).
interface cp0_ctrl_if #(parameter int NUM_HW_INT = 6);
   logic [NUM_HW_INT-1:0] i_ext_int;
   logic                  i_inst_valid;
   logic [4:0]            i_ra;
   logic [31:0]           o_rdata;
   logic                  i_we;
   logic [4:0]            i_wa;
   logic [31:0]           i_wdata;
   logic                  i_exc_valid;
   logic [4:0]            i_exc_code;
   logic                  i_exc_bad_en;
   logic [31:0]           i_badvaddr;
   logic [31:0]           i_exc_pc;
   logic                  i_exc_in_ds;
   logic                  i_eret;
   logic                  o_flush;
   logic [31:0]           o_flush_pc;
   logic                  o_int_pending;
   modport master(output i_ext_int, i_inst_valid, i_ra, i_we, i_wa, i_wdata, i_exc_valid, i_exc_code,
                  i_exc_bad_en, i_badvaddr, i_exc_pc, i_exc_in_ds, i_eret,
                  input o_rdata, o_flush, o_flush_pc, o_int_pending);
   modport slave(input i_ext_int, i_inst_valid, i_ra, i_we, i_wa, i_wdata, i_exc_valid, i_exc_code,
                 i_exc_bad_en, i_badvaddr, i_exc_pc, i_exc_in_ds, i_eret,
                 output o_rdata, o_flush, o_flush_pc, o_int_pending);
endinterface

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS32 CP0 for the M stage (interrupt/exception/ERET arbitration, Count prescaler).
// Define CP0_TIMER_INT_EN to enable the sticky Compare-match timer interrupt (Cause.TI).
module cp0_ctrl #(
   parameter int          NUM_HW_INT = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter logic [31:0] PRID_VALUE = 32'h00004220
) (
   input logic       clk,
   input logic       resetn,
   cp0_ctrl_if.slave bus
);
   logic [31:0] r_badv, r_count, r_cmp, r_epc, r_div;
   logic [7:0]  r_im;
   logic        r_exl, r_ie, r_bd;
   logic [1:0]  r_swip;
   logic [5:0]  r_hw;
   logic [4:0]  r_code;
   logic        w_ti, w_int, w_exc, w_trap, w_eret, w_we, w_tick;
   logic [5:0]  w_ext;
   logic [7:0]  w_ip;
   assign w_ext  = 6'(bus.i_ext_int[NUM_HW_INT-1:0]);
   assign w_ip   = {w_ti | r_hw[5], r_hw[4:0], r_swip};
   assign bus.o_int_pending = resetn & |(r_im & w_ip);
   assign w_int  = bus.o_int_pending & bus.i_inst_valid & r_ie & ~r_exl;
   assign w_exc  = resetn & ~w_int & bus.i_exc_valid;
   assign w_trap = w_int | w_exc;
   assign w_eret = resetn & ~w_trap & bus.i_eret;
   // any trap or ERET in the cycle suppresses MTC0 completely
   assign w_we   = bus.i_we & ~w_trap & ~bus.i_eret;
   assign w_tick = r_div == 32'(COUNT_DIV - 1);
   assign bus.o_flush    = w_trap | w_eret;
   assign bus.o_flush_pc = w_eret ? r_epc : EXC_VECTOR;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         {r_badv, r_count, r_cmp, r_epc, r_div} <= '0;
         {r_im, r_exl, r_ie, r_bd, r_swip, r_hw, r_code} <= '0;
      end else begin
         r_hw <= w_ext;
         if (w_we && bus.i_wa == 5'd9) begin
            r_count <= bus.i_wdata;
            r_div   <= '0;
         end else begin
            r_div   <= w_tick ? '0 : r_div + 32'd1;
            r_count <= r_count + 32'(w_tick);
         end
         if (w_trap) begin
            r_exl  <= 1'b1;
            r_code <= w_int ? 5'd0 : bus.i_exc_code;
            if (!r_exl) begin
               r_epc <= bus.i_exc_in_ds ? bus.i_exc_pc - 32'd4 : bus.i_exc_pc;
               r_bd  <= bus.i_exc_in_ds;
            end
            if (w_exc && bus.i_exc_bad_en) r_badv <= bus.i_badvaddr;
         end
         if (w_eret) r_exl <= 1'b0;
         if (w_we) begin
            case (bus.i_wa)
               5'd11: r_cmp <= bus.i_wdata;
               5'd12: {r_im, r_exl, r_ie} <= {bus.i_wdata[15:8], bus.i_wdata[1:0]};
               5'd13: r_swip <= bus.i_wdata[9:8];
               5'd14: r_epc <= bus.i_wdata;
               default: ;
            endcase
         end
      end
   end
`ifdef CP0_TIMER_INT_EN
   logic r_armed, r_ti;
   // a Compare write clears TI even if the match would set it this cycle
   always_ff @(posedge clk) begin
      if (!resetn) {r_armed, r_ti} <= '0;
      else if (w_we && bus.i_wa == 5'd11) {r_armed, r_ti} <= 2'b10;
      else if (r_armed && r_count == r_cmp) r_ti <= 1'b1;
   end
   assign w_ti = r_ti;
`else
   assign w_ti = 1'b0;
`endif
   always_comb begin
      bus.o_rdata = '0;
      case (bus.i_ra)
         5'd8:  bus.o_rdata = r_badv;
         5'd9:  bus.o_rdata = r_count;
         5'd11: bus.o_rdata = r_cmp;
         5'd12: bus.o_rdata = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
         5'd13: bus.o_rdata = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_code, 2'b00};
         5'd14: bus.o_rdata = r_epc;
         5'd15: bus.o_rdata = PRID_VALUE;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed test-plan steps plus randomized traffic checked against a behavioural CP0 model.
module tb_cp0_ctrl;
   localparam int          COUNT_DIV = 2;
   localparam logic [31:0] VEC       = 32'hBFC00380;
   localparam logic [31:0] PRID      = 32'h00004220;
   logic clk = 1'b0, resetn = 1'b0;
   int   n_checks = 0, n_err = 0;
   always #5 clk = ~clk;
   cp0_ctrl_if #(.NUM_HW_INT(6)) bus();
   cp0_ctrl #(.NUM_HW_INT(6), .COUNT_DIV(COUNT_DIV), .EXC_VECTOR(VEC), .PRID_VALUE(PRID))
      dut(.clk(clk), .resetn(resetn), .bus(bus));
   // model: Count is derived from cycles elapsed since its last load
   logic [31:0] m_badv, m_base, m_cmp, m_status, m_epc;
   longint      m_cyc;
   logic [1:0]  m_swip;
   logic [5:0]  m_hw;
   logic [4:0]  m_code;
   logic        m_bd, m_ti, m_armed;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic m_reset();
      {m_badv, m_base, m_cmp, m_epc} = '0;
      m_status = 32'h00400000;
      m_cyc = 0;
      {m_swip, m_hw, m_code, m_bd, m_ti, m_armed} = '0;
   endtask
   function automatic logic [31:0] m_count();
      return m_base + 32'(m_cyc / COUNT_DIV);
   endfunction
   function automatic logic [7:0] m_ip();
      return {m_ti | m_hw[5], m_hw[4:0], m_swip};
   endfunction
   function automatic logic m_pend();
      return resetn && ((m_status[15:8] & m_ip()) != 8'd0);
   endfunction
   task automatic m_events(output logic it, output logic et, output logic er);
      it = m_pend() && bus.i_inst_valid && m_status[0] && !m_status[1];
      et = resetn && !it && bus.i_exc_valid;
      er = resetn && !it && !et && bus.i_eret;
   endtask
   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:  return m_badv;
         5'd9:  return m_count();
         5'd11: return m_cmp;
         5'd12: return m_status;
         5'd13: return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
         5'd14: return m_epc;
         5'd15: return PRID;
         default: return 32'd0;
      endcase
   endfunction
   task automatic m_edge();
      logic it, et, er, mw;
      logic [31:0] cnt;
      if (!resetn) begin
         m_reset();
         return;
      end
      m_events(it, et, er);
      mw  = bus.i_we && !(it || et) && !bus.i_eret;
      cnt = m_count();
`ifdef CP0_TIMER_INT_EN
      if (mw && bus.i_wa == 5'd11) begin
         m_ti = 1'b0;
         m_armed = 1'b1;
      end else if (m_armed && cnt == m_cmp) m_ti = 1'b1;
`endif
      m_cyc++;
      if (mw && bus.i_wa == 5'd9) begin
         m_base = bus.i_wdata;
         m_cyc = 0;
      end
      if (it || et) begin
         if (!m_status[1]) begin
            m_epc = bus.i_exc_in_ds ? bus.i_exc_pc - 32'd4 : bus.i_exc_pc;
            m_bd  = bus.i_exc_in_ds;
         end
         m_status[1] = 1'b1;
         m_code = it ? 5'd0 : bus.i_exc_code;
         if (et && bus.i_exc_bad_en) m_badv = bus.i_badvaddr;
      end
      if (er) m_status[1] = 1'b0;
      if (mw) begin
         case (bus.i_wa)
            5'd11: m_cmp = bus.i_wdata;
            5'd12: m_status = (m_status & ~32'h0000FF03) | (bus.i_wdata & 32'h0000FF03);
            5'd13: m_swip = bus.i_wdata[9:8];
            5'd14: m_epc = bus.i_wdata;
            default: ;
         endcase
      end
      m_hw = bus.i_ext_int;
   endtask
   // compare outputs mid-cycle, then advance model and DUT by one edge
   task automatic cycle();
      logic it, et, er;
      @(negedge clk);
      m_events(it, et, er);
      check("flush", bus.o_flush, it || et || er);
      check("flush_pc", bus.o_flush_pc, er ? m_epc : VEC);
      check("int_pending", bus.o_int_pending, m_pend());
      check("rdata", bus.o_rdata, m_read(bus.i_ra));
      @(posedge clk);
      m_edge();
      #1;
   endtask
   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      bus.i_ra = a;
      #1;
      d = bus.o_rdata;
   endtask
   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.i_we = 1'b1; bus.i_wa = a; bus.i_wdata = d;
      cycle();
      bus.i_we = 1'b0;
   endtask
   task automatic idle();
      {bus.i_ext_int, bus.i_inst_valid, bus.i_ra, bus.i_we, bus.i_wa, bus.i_wdata} = '0;
      {bus.i_exc_valid, bus.i_exc_code, bus.i_exc_bad_en, bus.i_badvaddr} = '0;
      {bus.i_exc_pc, bus.i_exc_in_ds, bus.i_eret} = '0;
   endtask
   logic [31:0] d, c, s;
   logic        seen;
   initial begin
      idle();
      m_reset();
      @(posedge clk);
      #1;
      cycle();
      rd(5'd12, d); check("rst_status", d, 32'h00400000);
      rd(5'd13, d); check("rst_cause", d, 32'd0);
      rd(5'd15, d); check("rst_prid", d, PRID);
      check("rst_flush", bus.o_flush, 1'b0);
      resetn = 1'b1;
      bus.i_ra = 5'd9;
      repeat (20) cycle();
      check("count20", bus.o_rdata, 32'd10);
      mtc0(5'd9, 32'hFFFFFFFF);
      repeat (2) cycle();
      check("count_wrap", bus.o_rdata, 32'd0);
      mtc0(5'd12, 32'h00000401);
      bus.i_ext_int = 6'b000001; bus.i_exc_pc = 32'h80001000;
      bus.i_inst_valid = 1'b1;
      cycle();
      check("int_flush", bus.o_flush, 1'b1);
      check("int_flush_pc", bus.o_flush_pc, VEC);
      cycle();
      bus.i_inst_valid = 1'b0; bus.i_ext_int = '0;
      rd(5'd14, d); check("int_epc", d, 32'h80001000);
      rd(5'd13, c); check("int_code", c[6:2], 5'd0);
      rd(5'd12, s); check("int_exl", s[1], 1'b1);
      mtc0(5'd12, 32'd0);
      bus.i_exc_valid = 1'b1; bus.i_exc_code = 5'd4; bus.i_exc_bad_en = 1'b1;
      bus.i_exc_in_ds = 1'b1; bus.i_exc_pc = 32'hBFC00104; bus.i_badvaddr = 32'h3;
      cycle();
      bus.i_exc_valid = 1'b0; bus.i_exc_bad_en = 1'b0; bus.i_exc_in_ds = 1'b0;
      rd(5'd14, d); check("adel_epc", d, 32'hBFC00100);
      rd(5'd13, c); check("adel_bd", c[31], 1'b1); check("adel_code", c[6:2], 5'd4);
      rd(5'd8, d); check("adel_badv", d, 32'h3);
      bus.i_exc_valid = 1'b1; bus.i_exc_code = 5'd10; bus.i_exc_pc = 32'h00001234;
      cycle();
      bus.i_exc_valid = 1'b0;
      rd(5'd14, d); check("nested_epc", d, 32'hBFC00100);
      rd(5'd13, c); check("nested_code", c[6:2], 5'd10);
      bus.i_exc_valid = 1'b1; bus.i_exc_code = 5'd8;
      mtc0(5'd14, 32'hDEADBEEF);
      bus.i_exc_valid = 1'b0;
      rd(5'd14, d); check("mtc0_dropped", d, 32'hBFC00100);
      bus.i_eret = 1'b1;
      #1;
      check("eret_flush", bus.o_flush, 1'b1);
      check("eret_pc", bus.o_flush_pc, 32'hBFC00100);
      cycle();
      bus.i_eret = 1'b0;
      rd(5'd12, s); check("eret_exl", s[1], 1'b0);
`ifdef CP0_TIMER_INT_EN
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd5);
      mtc0(5'd12, 32'h00008001);
      bus.i_inst_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.o_flush) seen = 1'b1;
         else cycle();
      end
      check("timer_int", seen, 1'b1);
      rd(5'd13, c); check("timer_ti", c[30], 1'b1);
      cycle();
      bus.i_inst_valid = 1'b0;
      mtc0(5'd11, 32'd100);
      rd(5'd13, c); check("timer_ti_clr", c[30], 1'b0);
`endif
      for (int i = 0; i < 3000; i++) begin
         resetn = ($urandom_range(99) != 0);
         if ($urandom_range(9) == 0) bus.i_ext_int = 6'($urandom);
         bus.i_inst_valid = $urandom_range(1);
         bus.i_ra = 5'($urandom);
         bus.i_we = ($urandom_range(4) == 0);
         case ($urandom_range(7))
            0: bus.i_wa = 5'd9;
            1: bus.i_wa = 5'd11;
            2, 3: bus.i_wa = 5'd12;
            4: bus.i_wa = 5'd13;
            5: bus.i_wa = 5'd14;
            default: bus.i_wa = 5'($urandom);
         endcase
         bus.i_wdata = ($urandom_range(3) == 0) ? m_count() + 32'($urandom_range(3)) : $urandom;
         bus.i_exc_valid = ($urandom_range(15) == 0);
         bus.i_exc_code = 5'($urandom);
         bus.i_exc_bad_en = $urandom_range(1);
         bus.i_badvaddr = $urandom;
         bus.i_exc_pc = $urandom & ~32'd3;
         bus.i_exc_in_ds = $urandom_range(1);
         bus.i_eret = ($urandom_range(15) == 0);
         cycle();
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised MIPS32 coprocessor-0 controller for the memory stage. It holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId, and arbitrates interrupts, synchronous exceptions and ERET. It produces a single-cycle flush with a redirect PC. Relative to the previous generation it adds:
- a configurable number of hardware interrupt lines;
- a Count prescaler;
- a sticky Compare-match timer interrupt;
- a PRId register;
- nested-exception EPC protection;
- a defined precedence between MTC0 and trap events.

## Interface
- NUM_HW_INT, 6, hardware interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2]
- COUNT_DIV, 2, clk cycles per Count increment (>=1)
- EXC_VECTOR, 32'hBFC00380, redirect target for interrupts/exceptions
- PRID_VALUE, 32'h00004220, read-only PRId contents
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ext_int  in  NUM_HW_INT  level-sensitive hardware interrupt requests
- inst_valid  in  1  M stage holds a committable instruction
- ra  in  5  MFC0 read address
- rdata  out  32  MFC0 read data (combinational)
- we  in  1  MTC0 write enable
- wa  in  5  MTC0 write address
- wdata  in  32  MTC0 write data
- exc_valid  in  1  synchronous exception in M
- exc_code  in  5  ExcCode for exc_valid
- exc_bad_en  in  1  exception carries a bad address (AdEL/AdES)
- badvaddr  in  32  faulting address
- exc_pc  in  32  PC of the M-stage instruction
- exc_in_ds  in  1  M instruction is in a branch delay slot
- eret  in  1  ERET in M
- flush  out  1  redirect pipeline this cycle
- flush_pc  out  32  redirect target
- int_pending  out  1  unmasked interrupt present (Status.IM & Cause.IP nonzero)

## Operation
- Register map and reset values:
  - 8 BadVAddr: 0
  - 9 Count: 0
  - 11 Compare: 0
  - 12 Status: 32'h00400000
  - 13 Cause: 0
  - 14 EPC: 0
  - 15 PRId: PRID_VALUE
  - All other addresses read 0.
- Writable masks:
  - Status: [15:8] IM, [1] EXL, [0] IE.
  - Cause: [9:8] software IP only.
  - Count, Compare, EPC: full width.
  - BadVAddr and PRId: not writable.
- Cause.IP[2+NUM_HW_INT-1:2] is resampled from ext_int every cycle. Unused IP bits read 0.
- Prescaler: a divider counter counts 0..COUNT_DIV-1. Count increments when the divider wraps, and Count wraps 32'hFFFFFFFF -> 0.
  - An MTC0 to Count loads wdata and resets the divider to 0.
- Event priority, evaluated each cycle (highest first):
  1. Interrupt: taken when inst_valid & Status.IE & ~Status.EXL & int_pending. ExcCode=0.
  2. Exception: taken when exc_valid. ExcCode=exc_code. BadVAddr<=badvaddr if exc_bad_en.
  3. ERET: Status.EXL<=0, flush_pc=EPC.
- Trap entry (cases 1 and 2):
  - flush=1, flush_pc=EXC_VECTOR, Status.EXL<=1.
  - If EXL was 0: EPC<=exc_in_ds ? exc_pc-4 : exc_pc, and Cause.BD<=exc_in_ds.
  - If EXL was already 1: EPC and BD are unchanged. ExcCode is still updated.
- MTC0 in the same cycle as a trap or ERET is dropped entirely, including the Count-divider reset.
- ERET and exc_valid together: the exception wins.
- rdata returns committed (pre-edge) state. A write becomes visible the cycle after we.

## Timing
- flush and flush_pc are combinational in the event cycle. All register effects land at the next clk edge.
- int_pending reflects IP sampled the previous cycle, so ext_int-to-flush latency is 1 cycle.
- Reset outputs: flush=0, flush_pc=EXC_VECTOR, int_pending=0, rdata=value of addressed reset register.
- Reset mid-sequence clears the divider, the timer-armed flag and TI. No pending event survives reset.

## Configuration
- CP0_TIMER_INT_EN defined:
  - An armed flag is set by the first MTC0 to Compare and cleared by reset.
  - When armed and Count==Compare (checked each cycle), Cause.TI[30] is set and held.
  - Cause.IP[7] = TI | (NUM_HW_INT==6 ? ext_int[5] : 0).
  - TI is cleared only by an MTC0 to Compare; a write that sets TI in the same cycle clears it instead.
- Undefined: no armed flag, TI reads 0 and IP[7] is driven only by ext_int[5]. Count and Compare remain readable and writable.

## Test plan
- Reset, then read 12/13/15 -> 32'h00400000, 0, PRID_VALUE. flush=0.
- COUNT_DIV=2: hold for 20 cycles -> Count=10. MTC0 Count=32'hFFFFFFFF, wait 2 cycles -> Count=0.
- Status=32'h00000401 (IM2, IE), raise ext_int[0] -> flush one cycle later, flush_pc=32'hBFC00380, EPC=exc_pc, Cause[6:2]=0, EXL=1.
- AdEL with exc_in_ds=1, exc_pc=32'hBFC00104, badvaddr=32'h00000003 -> EPC=32'hBFC00100, BD=1, BadVAddr=3, ExcCode=4. A second exception while EXL=1 leaves EPC unchanged.
- MTC0 EPC plus exc_valid in the same cycle -> write dropped. ERET then gives flush_pc=old EPC and EXL=0.
- CP0_TIMER_INT_EN: Compare=5, Status=32'h00008001 -> TI=1 and an interrupt is taken. MTC0 Compare -> TI=0 next cycle.
